// File: rtl/conv_pkg.sv
// Shared constants and saturating arithmetic for the convolution MAC datapath.
package conv_pkg;

    localparam int CONV_MAX_W = 64;

    function automatic int CONV_TREE_LVLS(input int k);
        return (k * k > 1) ? $clog2(k * k) : 0;
    endfunction

    // Exact add in CONV_MAX_W bits, then clamp to the signed range of a w-bit value.
    function automatic logic signed [CONV_MAX_W-1:0] conv_sat_add(
        input logic signed [CONV_MAX_W-1:0] a,
        input logic signed [CONV_MAX_W-1:0] b,
        input int                           w
    );
        logic signed [CONV_MAX_W-1:0] s;
        logic signed [CONV_MAX_W-1:0] hi;
        logic signed [CONV_MAX_W-1:0] lo;
        s  = a + b;
        hi = (CONV_MAX_W'(1) << (w - 1)) - CONV_MAX_W'(1);
        lo = -hi - CONV_MAX_W'(1);
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Pipelined signed adder tree: one register level per pairwise reduction,
// an odd leftover element is carried forward through a plain delay register.
module conv_adder_tree #(
    parameter int IN_W = 18,
    parameter int N    = 9
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         en,
    input  logic                                         in_valid,
    input  logic [N*IN_W-1:0]                            in_data,
    output logic                                         out_valid,
    output logic signed [IN_W+((N > 1) ? $clog2(N) : 0)-1:0] out_data
);
    localparam int LVLS  = (N > 1) ? $clog2(N) : 0;
    localparam int OUT_W = IN_W + LVLS;

    function automatic int lvlCount(input int l);
        return (N + (1 << l) - 1) >> l;
    endfunction

    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        localparam int CNT = lvlCount(l);
        logic [CNT*OUT_W-1:0] node;
        logic                 vld;

        if (l == 0) begin : g_in
            always_comb begin
                for (int j = 0; j < N; j++)
                    node[j*OUT_W +: OUT_W] = OUT_W'($signed(in_data[j*IN_W +: IN_W]));
            end
            assign vld = in_valid;
        end else begin : g_reg
            localparam int PCNT = lvlCount(l - 1);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    node <= '0;
                    vld  <= 1'b0;
                end else if (en) begin
                    vld <= g_lvl[l-1].vld;
                    for (int j = 0; j < CNT; j++) begin
                        if (2*j + 1 < PCNT)
                            node[j*OUT_W +: OUT_W] <= OUT_W'(
                                $signed(g_lvl[l-1].node[2*j*OUT_W +: OUT_W]) +
                                $signed(g_lvl[l-1].node[(2*j+1)*OUT_W +: OUT_W]));
                        else
                            node[j*OUT_W +: OUT_W] <= g_lvl[l-1].node[2*j*OUT_W +: OUT_W];
                    end
                end
            end
        end
    end

    assign out_valid = g_lvl[LVLS].vld;
    assign out_data  = $signed(g_lvl[LVLS].node);

endmodule

// File: rtl/conv_mac_array.sv
// KxK signed convolution MAC: per-beat products, pipelined reduction, and
// saturating per-pixel channel accumulation with bias and optional ReLU.
module conv_mac_array
    import conv_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int K     = 3,
    parameter int ACC_W = 2*WIDTH+8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [K*K*WIDTH-1:0]    win,
    input  logic [K*K*WIDTH-1:0]    wgt,
    input  logic signed [ACC_W-1:0] bias,
    input  logic                    relu_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data
);
    localparam int NE    = K*K;
    localparam int PW    = 2*WIDTH;
    localparam int ST    = CONV_TREE_LVLS(K);
    localparam int SUM_W = PW + ST;

    logic                    en;
    logic [NE*PW-1:0]        prod_q;
    logic                    s0_valid_q;
    logic [ST:0]             first_q, last_q, relu_q;
    logic [ST:0][ACC_W-1:0]  bias_q;
    logic                    tree_valid;
    logic signed [SUM_W-1:0] tree_sum;
    logic signed [ACC_W-1:0] acc_q, acc_d, res_q, res_d, nxt;
    logic                    sat_q, sat_d, res_valid_q, res_valid_d, nsat;
    logic signed [CONV_MAX_W-1:0] base, addend, sat_sum;
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] out_data_q;

    assign en        = !(out_valid_q && !out_ready);
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Beat sideband rides a shift chain whose last tap lines up with the tree output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q     <= '0;
            s0_valid_q <= 1'b0;
            first_q    <= '0;
            last_q     <= '0;
            relu_q     <= '0;
            bias_q     <= '0;
        end else if (en) begin
            s0_valid_q <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < NE; i++)
                    prod_q[i*PW +: PW] <= PW'($signed(win[i*WIDTH +: WIDTH]) *
                                              $signed(wgt[i*WIDTH +: WIDTH]));
                first_q[0] <= in_first;
                last_q[0]  <= in_last;
                relu_q[0]  <= relu_en;
                bias_q[0]  <= bias;
            end
            for (int i = 1; i <= ST; i++) begin
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
                relu_q[i]  <= relu_q[i-1];
                bias_q[i]  <= bias_q[i-1];
            end
        end
    end

    conv_adder_tree #(.IN_W(PW), .N(NE)) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (s0_valid_q),
        .in_data   (prod_q),
        .out_valid (tree_valid),
        .out_data  (tree_sum)
    );

    // Overflow is detected by comparing the clamped sum with the exact wide sum;
    // once clamped, the pixel stays pinned until its last beat.
    always_comb begin
        acc_d       = acc_q;
        sat_d       = sat_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        base        = first_q[ST] ? CONV_MAX_W'($signed(bias_q[ST])) : CONV_MAX_W'(acc_q);
        addend      = CONV_MAX_W'(tree_sum);
        sat_sum     = conv_sat_add(base, addend, ACC_W);
        nxt         = ACC_W'(sat_sum);
        nsat        = (sat_sum != base + addend);
        if (sat_q && !first_q[ST]) begin
            nxt  = acc_q;
            nsat = 1'b1;
        end
        if (tree_valid) begin
            if (last_q[ST]) begin
                res_d       = (relu_q[ST] && nxt < 0) ? '0 : nxt;
                res_valid_d = 1'b1;
                acc_d       = '0;
                sat_d       = 1'b0;
            end else begin
                acc_d = nxt;
                sat_d = nsat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            sat_q       <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (en) begin
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            out_valid_q <= res_valid_q;
            if (res_valid_q) out_data_q <= res_q;
        end
    end

endmodule

// File: tb/tb_conv_mac_array.sv
// Scoreboard bench for conv_mac_array: directed beats push expected pixels,
// a negedge monitor pops and compares whenever a result is handed off.
module tb_conv_mac_array;
    localparam int WIDTH = 9;
    localparam int K     = 3;
    localparam int NE    = K*K;
    localparam int ACC_W = 22;

    typedef struct {
        logic signed [ACC_W-1:0] data;
        int                      cyc;
        int                      tag;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    in_first = 1'b0;
    logic                    in_last = 1'b0;
    logic [NE*WIDTH-1:0]     win = '0;
    logic [NE*WIDTH-1:0]     wgt = '0;
    logic signed [ACC_W-1:0] bias = '0;
    logic                    relu_en = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [ACC_W-1:0] out_data;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   acc;
    exp_t expQ[$];
    exp_t popped;

    conv_mac_array #(.WIDTH(WIDTH), .K(K), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .win       (win),
        .wgt       (wgt),
        .bias      (bias),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int d, input int cyc, input int tag);
        exp_t e;
        e.data = ACC_W'(d);
        e.cyc  = cyc;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    // Holds one beat on the bus until accepted; returns the cycle count at the accepting edge.
    task automatic applyStimulus(input int w, input int g, input int b, input bit f,
                                 input bit l, input bit r, output int acceptCyc);
        logic [WIDTH-1:0] wv;
        logic [WIDTH-1:0] gv;
        bit               taken;
        int               waited;
        wv = w[WIDTH-1:0];
        gv = g[WIDTH-1:0];
        win = {NE{wv}};
        wgt = {NE{gv}};
        bias = ACC_W'(b);
        in_first = f;
        in_last = l;
        relu_en = r;
        in_valid = 1'b1;
        taken = 1'b0;
        waited = 0;
        while (!taken && waited < 200) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        acceptCyc = cycle;
        if (!taken) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("pending_results", expQ.size(), 0);
        expQ.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_output: got %0d at cycle %0d, expected no output", out_data, cycle);
            end else begin
                popped = expQ.pop_front();
                if (out_data !== popped.data) begin
                    errors++;
                    $display("[TB] FAIL result_%0d: got %0d, expected %0d", popped.tag, out_data, popped.data);
                end else if (popped.cyc >= 0 && cycle != popped.cyc) begin
                    errors++;
                    $display("[TB] FAIL latency_%0d: got cycle %0d, expected cycle %0d", popped.tag, cycle, popped.cyc);
                end
            end
        end
        if (rst_n && out_valid && !out_ready) checkOutput("in_ready_stall", int'(in_ready), 0);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single channel, signed, relu");
        applyStimulus(1, 1, 0, 1, 1, 0, acc);    pushExp(9, acc + 6, 1);
        applyStimulus(-1, 2, 0, 1, 1, 0, acc);   pushExp(-18, acc + 6, 2);
        applyStimulus(-1, 2, 0, 1, 1, 1, acc);   pushExp(0, acc + 6, 3);
        applyStimulus(3, -2, 7, 1, 1, 1, acc);   pushExp(0, acc + 6, 4);
        applyStimulus(2, 3, -4, 1, 1, 1, acc);   pushExp(50, acc + 6, 5);
        drain();

        $display("[TB] multi channel");
        applyStimulus(1, 1, 5, 1, 0, 0, acc);
        applyStimulus(1, 1, 0, 0, 0, 0, acc);
        applyStimulus(1, 1, 0, 0, 1, 0, acc);    pushExp(32, acc + 6, 6);
        applyStimulus(1, 1, 100, 1, 0, 0, acc);
        applyStimulus(1, 1, 0, 1, 1, 0, acc);    pushExp(9, acc + 6, 7);
        applyStimulus(2, 2, 0, 0, 1, 0, acc);    pushExp(36, acc + 6, 8);
        drain();

        $display("[TB] saturation");
        for (int i = 0; i < 4; i++) applyStimulus(-256, -256, 0, i == 0, i == 3, 0, acc);
        pushExp(2097151, -1, 9);
        for (int i = 0; i < 4; i++) applyStimulus(-256, 255, 0, i == 0, i == 3, 0, acc);
        pushExp(-2097152, -1, 10);
        for (int i = 0; i < 5; i++) applyStimulus(i == 4 ? 1 : -256, i == 4 ? -1 : -256, 0, i == 0, i == 4, 0, acc);
        pushExp(2097151, -1, 11);
        drain();

        $display("[TB] backpressure");
        fork
            begin
                for (int v = 1; v <= 10; v++) begin
                    pushExp(9 * v, -1, 100 + v);
                    applyStimulus(v, 1, 0, 1, 1, 0, acc);
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] reset mid-pixel");
        out_ready = 1'b0;
        applyStimulus(1, 1, 0, 1, 1, 0, acc);
        applyStimulus(1, 1, 0, 1, 0, 0, acc);
        applyStimulus(1, 1, 0, 0, 0, 0, acc);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("held_out_valid", int'(out_valid), 1);
        checkOutput("held_out_data", out_data, 9);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", int'(out_valid), 0);
        checkOutput("midreset_out_data", out_data, 0);
        checkOutput("midreset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1, 1, 0, 0, 1, 0, acc);    pushExp(9, acc + 6, 12);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
